// File: rtl/vending_pkg.sv
// Shared types and defaults for the vending dispense arbiter.
//  state_e      : arbiter FSM states
//  DEF_*_CYCLES : default mechanism pulse lengths
//  max3         : helper used to size the shared down-counter
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DISPENSE = 3'd1,
    ST_CHANGE   = 3'd2,
    ST_DONE     = 3'd3,
    ST_GAP      = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam int DEF_MOTOR_CYCLES  = 4;
  localparam int DEF_CHANGE_CYCLES = 2;
  localparam int DEF_GAP_CYCLES    = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/vending_dispense_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//  req   in  N_REQ   request vector
//  ptr   in  PTR_W   highest-priority index this round
//  gnt   out N_REQ   one-hot winner (0 if no request)
//  idx   out PTR_W   index of winner
//  any   out 1       at least one request present
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // Offset i is tried in order ptr, ptr+1, ... with wrap; the inner loop only
  // indexes req with its own loop variable so every select stays constant.
  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && (k == j) && req[k]) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          idx    = PTR_W'(k);
        end
      end
    end
    any = found;
  end

endmodule

// File: rtl/vending_dispense_arbiter.sv
// Shares one dispense motor and one change ejector between N_REQ front-ends.
//  clk         in   clock, rising edge
//  rstn        in   async active-low reset
//  req         in   per-requester vend request (level)
//  req_change  in   per-requester change owed, sampled at grant edge
//  jam         in   mechanism jam sensor
//  fault_clr   in   operator clear of latched fault
//  grant       out  one-hot mechanism owner, held through service
//  done        out  one-cycle completion pulse to the owner
//  motor_on    out  dispense motor drive
//  change_on   out  change ejector drive
//  busy        out  high whenever not IDLE
//  fault       out  latched jam fault
// All outputs are registered: each *_d is the value for the state being entered.
module vending_dispense_arbiter
  import vending_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
  parameter int CHANGE_CYCLES = DEF_CHANGE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_change,
  input  logic             jam,
  input  logic             fault_clr,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             motor_on,
  output logic             change_on,
  output logic             busy,
  output logic             fault
);

  localparam int CNT_W = $clog2(max3(MOTOR_CYCLES, CHANGE_CYCLES, GAP_CYCLES) + 1);
  localparam int PTR_W = $clog2(N_REQ);

  // Counter holds "cycles remaining after this one", so expiry is cnt==0.
  localparam logic [CNT_W-1:0] MOTOR_LOAD  = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHANGE_LOAD = CNT_W'(CHANGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               chg_q, chg_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               motor_q, motor_d;
  logic               change_q, change_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic [PTR_W-1:0]   next_ptr;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Priority moves past the owner whether service completed or faulted.
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    chg_d    = chg_q;
    grant_d  = grant_q;
    done_d   = '0;
    motor_d  = 1'b0;
    change_d = 1'b0;
    fault_d  = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_DISPENSE;
          grant_d = arb_gnt;
          owner_d = arb_idx;
          chg_d   = req_change[arb_idx];
          cnt_d   = MOTOR_LOAD;
          motor_d = 1'b1;
        end
      end

      ST_DISPENSE: begin
        // jam is checked first so it beats a coincident counter expiry
        if (jam) begin
          state_d = ST_FAULT;
          grant_d = '0;
          fault_d = 1'b1;
          ptr_d   = next_ptr;
        end else if (cnt_q == '0) begin
          if (chg_q) begin
            state_d  = ST_CHANGE;
            cnt_d    = CHANGE_LOAD;
            change_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          motor_d = 1'b1;
        end
      end

      ST_CHANGE: begin
        if (jam) begin
          state_d = ST_FAULT;
          grant_d = '0;
          fault_d = 1'b1;
          ptr_d   = next_ptr;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          change_d = 1'b1;
        end
      end

      ST_DONE: begin
        ptr_d   = next_ptr;
        grant_d = '0;
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        fault_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      chg_q    <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      motor_q  <= 1'b0;
      change_q <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      chg_q    <= chg_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      motor_q  <= motor_d;
      change_q <= change_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign motor_on  = motor_q;
  assign change_on = change_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule
